// File: rtl/frame_sequencer.sv
// frame_sequencer: streams one frame from pixel memory through the top pipeline and writes results back in place
module frame_sequencer #(
    parameter int PIXEL_SIZE  = 24,
    parameter int ADDR_W      = 20,
    parameter int DIM_W       = 12,
    parameter int OUT_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [DIM_W-1:0]      width,
    input  logic [DIM_W-1:0]      height,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [PIXEL_SIZE-1:0] rd_data,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [PIXEL_SIZE-1:0] wr_data,
    output logic                  pix_en,
    output logic                  pix_hsync,
    output logic                  pix_vsync,
    output logic [PIXEL_SIZE-1:0] pix_data,
    input  logic [PIXEL_SIZE-1:0] pix_out
);
    localparam int LAT = OUT_LATENCY;

    typedef enum logic [2:0] {IDLE, VSYNC, ACTIVE, DRAIN, DONE} state_t;

    state_t                    state_q;
    logic [DIM_W-1:0]          width_q, height_q, col_q, row_q;
    logic [ADDR_W-1:0]         addr_q, pix_addr_q;
    logic                      busy_q, done_q, vsync_q, hsync_q, pix_en_q, pix_vld_q;
    logic [LAT-1:0]            vld_q;
    logic [LAT*ADDR_W-1:0]     wb_addr_q;
    logic [LAT:0]              vld_d;
    logic [(LAT+1)*ADDR_W-1:0] wb_addr_d;
    logic                      last_col, last_row, pend, pix_en_d;

    assign rd_en     = state_q == ACTIVE && !pause;
    assign rd_addr   = addr_q;
    assign last_col  = col_q == width_q - DIM_W'(1);
    assign last_row  = row_q == height_q - DIM_W'(1);
    // Write-back pipe contents after this cycle's shift; the incoming pixel occupies the low slot.
    assign vld_d     = {vld_q, pix_vld_q};
    assign wb_addr_d = {wb_addr_q, pix_addr_q};
    // Whether any write is still owed once this cycle completes.
    assign pend      = pix_en_q ? |vld_d[LAT-1:0] : |vld_d;
    assign pix_en_d  = rd_en || (state_q == DRAIN && !pause && pend);
    assign wr_en     = pix_en_q && vld_q[LAT-1];
    assign wr_addr   = wr_en ? wb_addr_q[LAT*ADDR_W-1 -: ADDR_W] : '0;
    assign wr_data   = wr_en ? pix_out : '0;
    assign pix_en    = pix_en_q;
    assign pix_hsync = hsync_q;
    assign pix_vsync = vsync_q;
    assign pix_data  = pix_vld_q ? rd_data : '0;
    assign busy      = busy_q;
    assign done      = done_q;

    // Frame FSM plus read counters, stream registers and the write-back address pipe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            pix_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vsync_q    <= 1'b0;
            hsync_q    <= 1'b0;
            pix_en_q   <= 1'b0;
            pix_vld_q  <= 1'b0;
            vld_q      <= '0;
            wb_addr_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            vsync_q   <= 1'b0;
            hsync_q   <= rd_en && col_q == '0;
            pix_en_q  <= pix_en_d;
            pix_vld_q <= rd_en;
            if (rd_en) pix_addr_q <= addr_q;
            if (pix_en_q) begin
                vld_q     <= vld_d[LAT-1:0];
                wb_addr_q <= wb_addr_d[LAT*ADDR_W-1:0];
            end
            case (state_q)
                IDLE: if (start) begin
                    width_q  <= width;
                    height_q <= height;
                    addr_q   <= base_addr;
                    col_q    <= '0;
                    row_q    <= '0;
                    busy_q   <= 1'b1;
                    // An empty frame falls through DRAIN (pipe already empty) so busy shows for a cycle.
                    if (width == '0 || height == '0) state_q <= DRAIN;
                    else begin
                        state_q <= VSYNC;
                        vsync_q <= 1'b1;
                    end
                end
                VSYNC: state_q <= ACTIVE;
                ACTIVE: if (rd_en) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    col_q  <= last_col ? '0 : col_q + DIM_W'(1);
                    if (last_col) row_q <= row_q + DIM_W'(1);
                    if (last_col && last_row) state_q <= DRAIN;
                end
                DRAIN: if (!pend) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed frame scenarios against frame_sequencer with a memory and top-pipeline model
module tb_frame_sequencer;
    localparam int PW = 24, AW = 20, DW = 12, LAT = 2;
    localparam logic [PW-1:0] KEY = 24'h5A5A5A;

    logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, pause = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] width = '0, height = '0;
    logic busy, done, rd_en, wr_en, pix_en, pix_hsync, pix_vsync;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [PW-1:0] rd_data = '0, wr_data, pix_data, pix_out, tp0 = '0, tp1 = '0;

    int n_pass = 0, n_total = 0;
    int cyc = 0, rd_cnt, pen_cnt, vs_cnt, done_cnt, gap, bad, start_cyc, vs_cyc, done_cyc, last_wr;
    int hs_q[$];
    logic [AW-1:0] wa_q[$];
    logic [PW-1:0] wd_q[$];
    bit clr = 1'b0;

    always #5 clk = ~clk;

    frame_sequencer #(.PIXEL_SIZE(PW), .ADDR_W(AW), .DIM_W(DW), .OUT_LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause),
        .base_addr(base_addr), .width(width), .height(height),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pix_en(pix_en), .pix_hsync(pix_hsync), .pix_vsync(pix_vsync),
        .pix_data(pix_data), .pix_out(pix_out)
    );

    function automatic logic [PW-1:0] pat(input logic [AW-1:0] a);
        return {4'hA, a};
    endfunction

    // frame memory: synchronous read
    always @(posedge clk) if (rd_en) rd_data <= pat(rd_addr);

    // top: out = data ^ KEY, LAT enabled cycles later
    always @(posedge clk) if (pix_en) begin
        tp0 <= pix_data ^ KEY;
        tp1 <= tp0;
    end
    assign pix_out = tp1;

    // monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (clr) begin
            rd_cnt = 0; pen_cnt = 0; vs_cnt = 0; done_cnt = 0; gap = 0; bad = 0;
            start_cyc = 0; vs_cyc = 0; done_cyc = 0; last_wr = 0;
            hs_q.delete(); wa_q.delete(); wd_q.delete();
        end else begin
            if (start && !busy) start_cyc = cyc;
            if (rd_en) rd_cnt++;
            if (busy && pen_cnt > 0 && !pix_en) gap++;
            if (pix_en) begin
                if (pix_hsync) hs_q.push_back(pen_cnt);
                pen_cnt++;
            end
            if (pix_vsync) begin vs_cnt++; vs_cyc = cyc; end
            if (wr_en) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); last_wr = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (wr_en && !pix_en) bad++;
            if (!pix_en && (pix_hsync || pix_data != '0)) bad++;
        end
    end

    task automatic clear();
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    // one frame; pause over cycles [pa, pa+pl) after start, optional stray start at cycle ri
    task automatic run(input logic [AW-1:0] b, input int w, input int h, input int pa, input int pl, input int ri);
        clear();
        @(posedge clk); #1;
        base_addr = b; width = DW'(w); height = DW'(h); start = 1'b1;
        for (int i = 1; i < 400; i++) begin
            @(posedge clk); #1;
            start = (i == ri);
            if (i == ri) begin base_addr = 20'h300; width = 9; height = 7; end
            pause = (i >= pa && i < pa + pl);
            if (done_cnt > 0) break;
        end
        start = 1'b0; pause = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_total++; if (done_cnt !== 1) $display("FAIL run_done count got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #10;
        n_total++; if ({busy, done, rd_en, wr_en, pix_en, pix_hsync, pix_vsync} !== 7'b0) $display("FAIL reset_ctrl got %b want 0", {busy, done, rd_en, wr_en, pix_en, pix_hsync, pix_vsync}); else n_pass++;
        n_total++; if ({rd_addr, wr_addr, wr_data, pix_data} !== '0) $display("FAIL reset_data got %h want 0", {rd_addr, wr_addr, wr_data, pix_data}); else n_pass++;
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [AW-1:0] ea;
        run(20'h100, 4, 2, 0, 0, 0);
        n_total++; if (vs_cnt !== 1 || vs_cyc !== start_cyc + 1) $display("FAIL t1_vsync got %0d@%0d want 1@%0d", vs_cnt, vs_cyc, start_cyc + 1); else n_pass++;
        n_total++; if (rd_cnt !== 8) $display("FAIL t1_reads got %0d want 8", rd_cnt); else n_pass++;
        n_total++; if (pen_cnt !== 8 + LAT) $display("FAIL t1_pix_en got %0d want %0d", pen_cnt, 8 + LAT); else n_pass++;
        n_total++; if (hs_q.size() !== 2 || hs_q[0] !== 0 || hs_q[1] !== 4) $display("FAIL t1_hsync got %p want '{0,4}", hs_q); else n_pass++;
        n_total++; if (wa_q.size() !== 8) $display("FAIL t1_wr_count got %0d want 8", wa_q.size()); else n_pass++;
        for (int k = 0; k < wa_q.size(); k++) begin
            ea = 20'h100 + AW'(k);
            n_total++; if (wa_q[k] !== ea || wd_q[k] !== (pat(ea) ^ KEY)) $display("FAIL t1_write%0d got %h/%h want %h/%h", k, wa_q[k], wd_q[k], ea, pat(ea) ^ KEY); else n_pass++;
        end
        n_total++; if (done_cyc !== last_wr + 1) $display("FAIL t1_done_time got %0d want %0d", done_cyc, last_wr + 1); else n_pass++;
        n_total++; if (gap !== 0 || bad !== 0) $display("FAIL t1_stream gap %0d bad %0d want 0 0", gap, bad); else n_pass++;
    endtask

    task automatic test_pause();
        logic [AW-1:0] ea;
        run(20'h100, 4, 2, 4, 3, 0);
        n_total++; if (gap !== 3) $display("FAIL t2_gap got %0d want 3", gap); else n_pass++;
        n_total++; if (rd_cnt !== 8 || pen_cnt !== 8 + LAT) $display("FAIL t2_counts got %0d/%0d want 8/%0d", rd_cnt, pen_cnt, 8 + LAT); else n_pass++;
        n_total++; if (wa_q.size() !== 8) $display("FAIL t2_wr_count got %0d want 8", wa_q.size()); else n_pass++;
        for (int k = 0; k < wa_q.size(); k++) begin
            ea = 20'h100 + AW'(k);
            n_total++; if (wa_q[k] !== ea || wd_q[k] !== (pat(ea) ^ KEY)) $display("FAIL t2_write%0d got %h/%h want %h/%h", k, wa_q[k], wd_q[k], ea, pat(ea) ^ KEY); else n_pass++;
        end
        n_total++; if (done_cyc !== start_cyc + 16) $display("FAIL t2_done_time got %0d want %0d", done_cyc, start_cyc + 16); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL t2_stream bad got %0d want 0", bad); else n_pass++;
    endtask

    task automatic test_empty();
        run(20'h40, 0, 5, 0, 0, 0);
        n_total++; if (rd_cnt !== 0 || pen_cnt !== 0 || wa_q.size() !== 0) $display("FAIL t3_activity got %0d/%0d/%0d want 0/0/0", rd_cnt, pen_cnt, wa_q.size()); else n_pass++;
        n_total++; if (vs_cnt !== 0) $display("FAIL t3_vsync got %0d want 0", vs_cnt); else n_pass++;
        n_total++; if (done_cyc !== start_cyc + 2) $display("FAIL t3_done_time got %0d want %0d", done_cyc, start_cyc + 2); else n_pass++;
    endtask

    task automatic test_restart_ignored();
        logic [AW-1:0] ea;
        run(20'h100, 4, 2, 0, 0, 5);
        n_total++; if (rd_cnt !== 8) $display("FAIL t4_reads got %0d want 8", rd_cnt); else n_pass++;
        n_total++; if (wa_q.size() !== 8) $display("FAIL t4_wr_count got %0d want 8", wa_q.size()); else n_pass++;
        for (int k = 0; k < wa_q.size(); k++) begin
            ea = 20'h100 + AW'(k);
            n_total++; if (wa_q[k] !== ea) $display("FAIL t4_addr%0d got %h want %h", k, wa_q[k], ea); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] ea;
        clear();
        @(posedge clk); #1;
        base_addr = 20'h100; width = 4; height = 2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        #3;
        n_total++; if ({busy, done, rd_en, wr_en, pix_en, pix_hsync, pix_vsync} !== 7'b0) $display("FAIL t5_reset_ctrl got %b want 0", {busy, done, rd_en, wr_en, pix_en, pix_hsync, pix_vsync}); else n_pass++;
        n_total++; if ({rd_addr, wr_addr, wr_data, pix_data} !== '0) $display("FAIL t5_reset_data got %h want 0", {rd_addr, wr_addr, wr_data, pix_data}); else n_pass++;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_total++; if (done_cnt !== 0 || busy !== 1'b0) $display("FAIL t5_aborted done %0d busy %b want 0 0", done_cnt, busy); else n_pass++;
        run(20'h200, 4, 2, 0, 0, 0);
        n_total++; if (vs_cnt !== 1 || wa_q.size() !== 8) $display("FAIL t5_rerun vsync %0d writes %0d want 1 8", vs_cnt, wa_q.size()); else n_pass++;
        for (int k = 0; k < wa_q.size(); k++) begin
            ea = 20'h200 + AW'(k);
            n_total++; if (wa_q[k] !== ea || wd_q[k] !== (pat(ea) ^ KEY)) $display("FAIL t5_write%0d got %h/%h want %h/%h", k, wa_q[k], wd_q[k], ea, pat(ea) ^ KEY); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        run(20'hFFFFF, 1, 3, 0, 0, 0);
        n_total++; if (hs_q.size() !== 3 || hs_q[0] !== 0 || hs_q[1] !== 1 || hs_q[2] !== 2) $display("FAIL t6_hsync got %p want '{0,1,2}", hs_q); else n_pass++;
        n_total++; if (wa_q.size() !== 3) $display("FAIL t6_wr_count got %0d want 3", wa_q.size()); else n_pass++;
        for (int k = 0; k < wa_q.size(); k++) begin
            ea = 20'hFFFFF + AW'(k);
            n_total++; if (wa_q[k] !== ea || wd_q[k] !== (pat(ea) ^ KEY)) $display("FAIL t6_write%0d got %h/%h want %h/%h", k, wa_q[k], wd_q[k], ea, pat(ea) ^ KEY); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_empty();
        test_restart_ignored();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
